wb_master_port: RTL



---
 rtl/wb_master_port_if.sv | 41 ++++
 rtl/wb_master_port.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/wb_master_port_if.sv
// Request/response port plus Wishbone B4 classic bus, as seen by wb_master_port.
// master modport: the initiator side; slave modport: requester + bus responder side.
interface wb_master_port_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int SEL_WIDTH  = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_adr;
  logic [DATA_WIDTH-1:0] req_dat;
  logic                  req_we;
  logic [SEL_WIDTH-1:0]  req_sel;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_dat;
  logic                  resp_err;
  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [DATA_WIDTH-1:0] wb_dat_o;
  logic                  wb_we_o;
  logic [SEL_WIDTH-1:0]  wb_sel_o;
  logic                  wb_stb_o;
  logic                  wb_cyc_o;
  logic [DATA_WIDTH-1:0] wb_dat_i;
  logic                  wb_ack_i;
  logic                  wb_err_i;
  logic                  wb_rty_i;

  modport master (
    input  req_valid, req_adr, req_dat, req_we, req_sel,
    output req_ready, resp_valid, resp_dat, resp_err,
    output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );

  modport slave (
    output req_valid, req_adr, req_dat, req_we, req_sel,
    input  req_ready, resp_valid, resp_dat, resp_err,
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
  );
endinterface

// File: rtl/wb_master_port.sv
// Wishbone B4 classic-cycle initiator: one request in, one bus cycle out,
// one-cycle completion pulse back. Handles ack/err/rty with bounded retry.
// Optional stall timeout: define WB_MASTER_TIMEOUT_EN.
module wb_master_port #(
  parameter int DATA_WIDTH      = 128,
  parameter int ADDR_WIDTH      = 32,
  parameter int BUS_GRANULARITY = 8,
  parameter int MAX_RETRY       = 3,
  parameter int TIMEOUT         = 255
)(
  input logic               clk,
  input logic               rst,
  wb_master_port_if.master  bus
);
  localparam int SEL_WIDTH = DATA_WIDTH / BUS_GRANULARITY;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUS     = 2'd1;
  localparam logic [1:0] S_BACKOFF = 2'd2;

  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

  // Parameter sanity: retry count is 4 bits, timeout counter is 16 bits.
  if (MAX_RETRY < 0 || MAX_RETRY > 15) begin : g_bad_retry
    $error("wb_master_port: MAX_RETRY out of range");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("wb_master_port: TIMEOUT out of range");
  end

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic                  we_q, we_d;
  logic [SEL_WIDTH-1:0]  sel_q, sel_d;
  logic [3:0]            retry_q, retry_d;
  logic                  rv_q, rv_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
`ifdef WB_MASTER_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0]           tmo_q, tmo_d;
`endif

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.wb_cyc_o   = (state_q == S_BUS);
  assign bus.wb_stb_o   = (state_q == S_BUS);
  assign bus.wb_adr_o   = adr_q;
  assign bus.wb_dat_o   = dat_q;
  assign bus.wb_we_o    = we_q;
  assign bus.wb_sel_o   = sel_q;
  assign bus.resp_valid = rv_q;
  assign bus.resp_err   = err_q;
  assign bus.resp_dat   = rdat_q;

  // Next-state: latch request, resolve termination (err > rty > ack), back off on retry.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    we_d    = we_q;
    sel_d   = sel_q;
    retry_d = retry_q;
    rv_d    = 1'b0;
    err_d   = err_q;
    rdat_d  = rdat_q;
`ifdef WB_MASTER_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          adr_d   = bus.req_adr;
          dat_d   = bus.req_dat;
          we_d    = bus.req_we;
          sel_d   = bus.req_sel;
          retry_d = 4'd0;
`ifdef WB_MASTER_TIMEOUT_EN
          tmo_d   = 16'd0;
`endif
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        if (bus.wb_err_i) begin
          rv_d    = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (bus.wb_rty_i) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 4'd1;
            state_d = S_BACKOFF;
          end else begin
            rv_d    = 1'b1;
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else if (bus.wb_ack_i) begin
          rv_d    = 1'b1;
          err_d   = 1'b0;
          if (!we_q) rdat_d = bus.wb_dat_i;
          state_d = S_IDLE;
        end
`ifdef WB_MASTER_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          rv_d    = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
`endif
      end
      S_BACKOFF: begin
`ifdef WB_MASTER_TIMEOUT_EN
        tmo_d   = 16'd0;
`endif
        state_d = S_BUS;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight transaction silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      retry_q <= 4'd0;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
      tmo_q   <= 16'd0;
`endif
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      retry_q <= retry_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
`ifdef WB_MASTER_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end
endmodule
